// File: rtl/lsu_if.sv
// Request/response handshake and data-memory bus between a requester and the LSU.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_MemRW;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_MemRW
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_MemRW
    );
endinterface

// File: rtl/lsu.sv
// RV32 load/store unit: one request at a time, stores are read-modify-write
// on a word-wide memory with a combinational read port.
module lsu #(
    parameter int MEM_BYTES = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [31:0] MAX_BASE = 32'(MEM_BYTES - 4);

    state_t      state;
    req_t        rq;
    logic [31:0] rbuf;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] in_base;
    logic [1:0]  in_off;
    logic        in_err;
    logic [4:0]  sh_amt;
    logic [31:0] rd_sh;
    logic [31:0] ld_val;
    logic [31:0] st_mask;
    logic [31:0] st_merged;

    assign in_base = bus.req_addr & ~32'd3;
    assign in_off  = bus.req_addr[1:0];

    // Unsigned compare on the aligned base: addresses near 2^32 never alias into range.
    always_comb begin
        in_err = 1'b0;
        if (in_base > MAX_BASE) in_err = 1'b1;
        case (bus.req_funct3[1:0])
            2'b01:   if (in_off[0])     in_err = 1'b1;
            2'b10:   if (in_off != 2'd0) in_err = 1'b1;
            default: ;
        endcase
        if (bus.req_we) begin
            if (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11) in_err = 1'b1;
        end else if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            in_err = 1'b1;
        end
    end

    assign sh_amt = {rq.addr[1:0], 3'b000};
    assign rd_sh  = bus.mem_rdata >> sh_amt;

    always_comb begin
        case (rq.funct3)
            3'b000:  ld_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  ld_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  ld_val = bus.mem_rdata;
            3'b100:  ld_val = {24'd0, rd_sh[7:0]};
            3'b101:  ld_val = {16'd0, rd_sh[15:0]};
            default: ld_val = 32'd0;
        endcase
    end

    always_comb begin
        case (rq.funct3)
            3'b000:  st_mask = 32'h0000_00FF << sh_amt;
            3'b001:  st_mask = 32'h0000_FFFF << sh_amt;
            3'b010:  st_mask = 32'hFFFF_FFFF;
            default: st_mask = 32'd0;
        endcase
        st_merged = (rbuf & ~st_mask) | ((rq.wdata << sh_amt) & st_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rq      <= '0;
            rbuf    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    rq      <= '{we: bus.req_we, funct3: bus.req_funct3,
                                 addr: bus.req_addr, wdata: bus.req_wdata};
                    rdata_q <= 32'd0;
                    err_q   <= in_err;
                    state   <= in_err ? RESP : ACCESS;
                end
                ACCESS: begin
                    rbuf <= bus.mem_rdata;
                    if (rq.we) begin
                        state <= WRITE;
                    end else begin
                        rdata_q <= ld_val;
                        state   <= RESP;
                    end
                end
                WRITE: begin
                    rdata_q <= 32'd0;
                    state   <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from state so reset kills a write in flight.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_MemRW = (state == WRITE);
    assign bus.mem_addr  = (state == ACCESS || state == WRITE) ? {rq.addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_wdata = (state == WRITE) ? st_merged : 32'd0;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a 32-byte little-endian memory model.
module tb_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    lsu_if bus();
    lsu #(.MEM_BYTES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [7:0]  mem [0:31] = '{0: 8'd10, 1: 8'd20, 2: 8'd30, 3: 8'd40,
                               18: 8'h6D, 19: 8'd200, default: 8'h00};
    int          wr_cnt = 0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;

    assign bus.mem_rdata = (bus.mem_addr <= 32'd28) ?
        {mem[bus.mem_addr[4:0] + 5'd3], mem[bus.mem_addr[4:0] + 5'd2],
         mem[bus.mem_addr[4:0] + 5'd1], mem[bus.mem_addr[4:0]]} : 32'd0;

    always @(posedge clk) begin
        if (bus.mem_MemRW && bus.mem_addr <= 32'd28) begin
            mem[bus.mem_addr[4:0]]        <= bus.mem_wdata[7:0];
            mem[bus.mem_addr[4:0] + 5'd1] <= bus.mem_wdata[15:8];
            mem[bus.mem_addr[4:0] + 5'd2] <= bus.mem_wdata[23:16];
            mem[bus.mem_addr[4:0] + 5'd3] <= bus.mem_wdata[31:24];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_MemRW) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
        end
    end

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat, output int pulses);
        int c0;
        @(negedge clk);
        c0 = wr_cnt;
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        pulses = wr_cnt - c0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.mem_MemRW !== 1'b0) begin errors++; $display("FAIL reset_memrw: got %b want 0", bus.mem_MemRW); end
        checks++; if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0 0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got rdata %h err %b want 0 0", bus.rsp_rdata, bus.rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        logic [31:0] rd; logic er; int lat, p;
        logic [2:0]  f3s [6] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] ads [6] = '{32'd0, 32'd19, 32'd19, 32'd18, 32'd18, 32'd2};
        logic [31:0] exp [6] = '{32'h281E140A, 32'hFFFFFFC8, 32'h000000C8,
                                 32'h0000C86D, 32'hFFFFC86D, 32'h0000001E};
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, f3s[i], ads[i], 32'd0, rd, er, lat, p);
            checks++; if (rd !== exp[i] || er !== 1'b0) begin errors++; $display("FAIL load%0d_data: got %h err %b want %h err 0", i, rd, er, exp[i]); end
            checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
            checks++; if (p != 0) begin errors++; $display("FAIL load%0d_nowrite: got %0d pulses want 0", i, p); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er; int lat, p;
        run_req(1'b1, 3'b001, 32'd2, 32'h1234BEEF, rd, er, lat, p);
        checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency: got %0d want 3", lat); end
        checks++; if (p != 1) begin errors++; $display("FAIL sh_pulses: got %0d want 1", p); end
        checks++; if (wr_addr !== 32'd0 || wr_data !== 32'hBEEF140A) begin errors++; $display("FAIL sh_write: got addr %h data %h want 0 BEEF140A", wr_addr, wr_data); end
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sh_rsp: got %h err %b want 0 err 0", rd, er); end
        run_req(1'b0, 3'b010, 32'd0, 32'd0, rd, er, lat, p);
        checks++; if (rd !== 32'hBEEF140A) begin errors++; $display("FAIL sh_readback: got %h want BEEF140A", rd); end
        run_req(1'b1, 3'b000, 32'd17, 32'h777777AB, rd, er, lat, p);
        checks++; if (p != 1 || wr_addr !== 32'd16 || wr_data !== 32'hC86DAB00) begin errors++; $display("FAIL sb_write: got %0d pulses addr %h data %h want 1 10 C86DAB00", p, wr_addr, wr_data); end
        run_req(1'b0, 3'b000, 32'd17, 32'd0, rd, er, lat, p);
        checks++; if (rd !== 32'hFFFFFFAB) begin errors++; $display("FAIL sb_readback: got %h want FFFFFFAB", rd); end
        run_req(1'b0, 3'b010, 32'd28, 32'd0, rd, er, lat, p);
        checks++; if (rd !== 32'd0 || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL lw_top_word: got %h err %b lat %0d want 0 0 2", rd, er, lat); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, p;
        logic        wes [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [7] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011, 3'b010, 3'b001};
        logic [31:0] ads [7] = '{32'd6, 32'd5, 32'd32, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd3};
        for (int i = 0; i < 7; i++) begin
            run_req(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, rd, er, lat, p);
            checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err%0d_flag: got err %b rdata %h want 1 0", i, er, rd); end
            checks++; if (lat != 1 || p != 0) begin errors++; $display("FAIL err%0d_timing: got lat %0d pulses %0d want 1 0", i, lat, p); end
        end
    endtask

    task automatic test_backpressure();
        int c0, n;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'd0; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
        checks++; if (!bus.rsp_valid) begin errors++; $display("FAIL bp_timeout: got rsp_valid 0 want 1"); end
        c0 = wr_cnt;
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hBEEF140A || bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got valid %b rdata %h ready %b want 1 BEEF140A 0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid); end
        checks++; if (wr_cnt != c0) begin errors++; $display("FAIL bp_ignored_req: got %0d pulses want 0", wr_cnt - c0); end
    endtask

    task automatic test_reset_in_write();
        logic [31:0] rd; logic er; int lat, p;
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'd1; bus.req_wdata = 32'h55;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.mem_MemRW !== 1'b1 || bus.mem_wdata !== 32'hBEEF550A) begin errors++; $display("FAIL rw_in_write: got memrw %b wdata %h want 1 BEEF550A", bus.mem_MemRW, bus.mem_wdata); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_MemRW !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL rw_memrw_drop: got memrw %b addr %h wdata %h want 0 0 0", bus.mem_MemRW, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL rw_outputs: got ready %b valid %b rdata %h err %b want 1 0 0 0", bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if ({mem[3], mem[2], mem[1], mem[0]} !== 32'hBEEF140A) begin errors++; $display("FAIL rw_mem_intact: got %h want BEEF140A", {mem[3], mem[2], mem[1], mem[0]}); end
        rst_n = 1'b1;
        run_req(1'b0, 3'b100, 32'd1, 32'd0, rd, er, lat, p);
        checks++; if (rd !== 32'h00000014 || er !== 1'b0) begin errors++; $display("FAIL rw_after_reset: got %h err %b want 00000014 0", rd, er); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_reset_in_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL provide parameter MEM_BYTES, default 32, giving the byte size of the attached data memory.
REQ-002 SHALL provide: clk  input  1  rising-edge clock.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide: req_valid  input  1; req_ready  output  1; req_we  input  1 (1=store); req_funct3  input  3 (RV32 load/store width code); req_addr  input  32 (byte address); req_wdata  input  32 (store data, low bits used).
REQ-005 SHALL provide: rsp_valid  output  1; rsp_ready  input  1; rsp_rdata  output  32 (load result); rsp_err  output  1 (misaligned, out of range or illegal funct3).
REQ-006 SHALL provide: mem_addr  output  32; mem_wdata  output  32; mem_MemRW  output  1 (1=write word on next clk edge); mem_rdata  input  32 (combinational little-endian word read at mem_addr).

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL, in IDLE with req_valid=1, latch we/funct3/addr/wdata on the clock edge; requests while not IDLE are not accepted.
REQ-009 SHALL classify at acceptance: base=addr&~3, off=addr[1:0]; error if base>MEM_BYTES-4, halfword with off odd, word with off!=0, load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010}.
REQ-010 SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0 on error; no memory write occurs.
REQ-011 SHALL go IDLE->ACCESS otherwise; in ACCESS drive mem_addr=base, mem_MemRW=0, and capture mem_rdata into word buffer rbuf at the edge.
REQ-012 SHALL go ACCESS->RESP for loads; rsp_rdata = lane(rbuf, off) for lb/lh sign-extended and lbu/lhu zero-extended, byte lane 8*off, halfword lane 8*off (off in {0,2}), word = rbuf.
REQ-013 SHALL go ACCESS->WRITE for stores; in WRITE drive mem_addr=base, mem_wdata=rbuf with only the addressed byte(s) replaced by wdata[7:0]/[15:0]/[31:0], mem_MemRW=1 for exactly this one cycle; then WRITE->RESP.
REQ-014 SHALL drive mem_MemRW combinationally from state: 1 only in WRITE; mem_addr=0 and mem_wdata=0 in IDLE and RESP.
REQ-015 SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err throughout RESP until rsp_ready=1, then RESP->IDLE; rsp_rdata=0 for stores.
REQ-016 SHALL give latency from acceptance edge to rsp_valid: error 1 cycle, load 2 cycles, store 3 cycles; rsp_ready held high gives throughput of one request per latency+1 cycles (no bypass from RESP).
REQ-017 SHALL keep rsp_rdata, rsp_err registered; all arithmetic on 32-bit unsigned addresses, no wrap-around into valid range.

Reset
REQ-018 SHALL, on rst_n=0 at any time, immediately enter IDLE and clear rsp_valid, rsp_rdata, rsp_err, all latched request fields and rbuf to 0.
REQ-019 SHALL deassert mem_MemRW immediately on reset, including mid-WRITE, so an interrupted store writes nothing; the pending response is discarded.
REQ-020 SHALL present after reset: req_ready=1, rsp_valid=0, mem_MemRW=0, mem_addr=0, mem_wdata=0.

Verification
REQ-021 Memory bytes 0..3 = 10,20,30,40; lw addr 0 -> rsp_valid 2 cycles after accept, rsp_rdata=0x281E140A, rsp_err=0, mem_MemRW never 1.
REQ-022 Byte 19 = 200; lb addr 19 -> 0xFFFFFFC8; lbu addr 19 -> 0x000000C8; lhu addr 18 -> 0x0000C86D.
REQ-023 sh addr 2, wdata 0x1234BEEF -> single mem_MemRW pulse at base 0 with mem_wdata=0xBEEF140A; subsequent lw addr 0 -> 0xBEEF140A.
REQ-024 lw addr 6, lh addr 5, lw addr 32, store funct3=100 -> each rsp_err=1 after 1 cycle, rsp_rdata=0, no mem_MemRW pulse.
REQ-025 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
REQ-026 Assert rst_n=0 during WRITE of sb addr 1 -> mem_MemRW drops same cycle, memory word 0 unchanged, outputs at reset values.
